// File: rtl/if_id_stage.sv
// rtl/if_id_stage.sv - PC register, IF/ID pipeline register and stall watchdog
//
// Purpose:
//   Owns the fetch PC and the IF/ID pipeline register. It consumes the
//   hazard unit's stall/flush controls and redirects the PC on a taken
//   branch or jump. It also counts consecutive PC_Keep cycles and raises a
//   sticky stall_timeout when a stall runs for MAX_STALL cycles.
//
// Optional feature macro: PERF_CNT_EN
//   When defined, stall_cnt and flush_cnt are saturating performance counters.
//   When undefined, both outputs are tied to zero and no counter flops exist.
//   The port list is the same in both builds.
//
// Ports:
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   PC_Keep, IF_ID_Hold            load-use stall: hold the PC / hold IF/ID
//   IF_ID_Flush                    replace the IF/ID contents with a bubble
//   Jump, jump_target              jump redirect
//   if_branch, branch_target       taken-branch redirect (highest priority)
//   inst_in                        instruction memory data at pc
//   pc                             current fetch address
//   IF_ID_PC/Inst/Valid            IF/ID register (PC+4, instruction, 0=bubble)
//   stall_timeout                  sticky runaway-stall flag
//   stall_cnt, flush_cnt           perf counters (zero unless PERF_CNT_EN)

module if_id_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INST  = 32'h0000_0000,
  parameter int          MAX_STALL = 8,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PC_Keep,
  input  logic             IF_ID_Hold,
  input  logic             IF_ID_Flush,
  input  logic             Jump,
  input  logic             if_branch,
  input  logic [31:0]      jump_target,
  input  logic [31:0]      branch_target,
  input  logic [31:0]      inst_in,
  output logic [31:0]      pc,
  output logic [31:0]      IF_ID_PC,
  output logic [31:0]      IF_ID_Inst,
  output logic             IF_ID_Valid,
  output logic             stall_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int RUN_W = $clog2(MAX_STALL + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MAX_STALL);

  logic [31:0]      pc_plus4;
  logic [31:0]      next_pc;
  logic             redirect;
  logic             stall_inc;
  logic [RUN_W-1:0] stall_run;
  logic [RUN_W-1:0] stall_run_next;

  assign pc_plus4 = pc + 32'd4;  // wraps naturally at 2^32
  assign redirect = if_branch | Jump;
  // A redirect wins over PC_Keep, so that cycle is not a real stall.
  assign stall_inc = PC_Keep & ~redirect;

  always_comb begin
    next_pc = pc_plus4;
    if (if_branch) begin
      next_pc = {branch_target[31:2], 2'b00};
    end else if (Jump) begin
      next_pc = {jump_target[31:2], 2'b00};
    end else if (PC_Keep) begin
      next_pc = pc;
    end
  end

  always_comb begin
    stall_run_next = '0;
    if (stall_inc) begin
      stall_run_next = (stall_run == RUN_MAX) ? stall_run : stall_run + RUN_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
    end else begin
      pc <= next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || IF_ID_Flush) begin
      IF_ID_Inst  <= NOP_INST;
      IF_ID_PC    <= 32'h0;
      IF_ID_Valid <= 1'b0;
    end else if (!IF_ID_Hold) begin
      IF_ID_Inst  <= inst_in;
      IF_ID_PC    <= pc_plus4;
      IF_ID_Valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_run     <= '0;
      stall_timeout <= 1'b0;
    end else begin
      stall_run <= stall_run_next;
      if (stall_run_next == RUN_MAX) begin
        stall_timeout <= 1'b1;
      end
    end
  end

`ifdef PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_inc && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (IF_ID_Flush && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
